// File: rtl/mult_div_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer and the main control unit.
package mult_div_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_sequencer_md_iter_core.sv
// Iterative mult/div datapath: one shift-add or restoring-subtract step per enable.
module md_iter_core
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             ld_opnd,
  input  logic [WIDTH-1:0] ld_hi,
  input  logic [WIDTH-1:0] ld_lo,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             en,
  input  logic             op_div,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH:0]   sum, rem_sh, diff;

  always_comb begin
    sum    = {1'b0, hi_q} + {1'b0, opnd_q};
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (ld) begin
      hi_d = ld_hi;
      lo_d = ld_lo;
      if (ld_opnd) opnd_d = opnd_i;
    end else if (en) begin
      if (op_div == MD_OP_DIV) begin
        // diff[WIDTH] set means the trial subtract went negative: restore
        if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = {1'b0, hi_q[WIDTH-1:1]};
        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_div_sequencer.sv
// MIPS mult/div sequencer: FSM, iteration counter, sign handling and HI/LO registers.
// Optional MD_UNSIGNED_OPS_EN adds op_unsigned for multu/divu.
//   state | meaning
//   IDLE  | waiting for start
//   PREP  | capture magnitudes/signs/op, load core
//   ITER  | WIDTH core iterations
//   FIX   | conditional negate of the raw result
//   DONE  | done pulse, HI/LO write unless divide-by-zero
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_div,
`ifdef MD_UNSIGNED_OPS_EN
  input  logic             op_unsigned,
`endif
  input  logic             abort,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             hilo_w,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_div_q, neg_res_q, neg_a_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_unsigned, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
  logic             core_ld, core_ld_opnd, core_en;
  logic [WIDTH-1:0] core_ld_hi, core_ld_lo, core_opnd, core_hi, core_lo;

`ifdef MD_UNSIGNED_OPS_EN
  assign is_unsigned = op_unsigned;
`else
  assign is_unsigned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start && !abort) state_d = ST_PREP;
      ST_PREP: begin
        if (abort) state_d = ST_IDLE;
        else if (op_div == MD_OP_DIV && src_b == '0) state_d = ST_DONE;
        else begin
          state_d = ST_ITER;
          cnt_d   = '0;
        end
      end
      ST_ITER: begin
        if (abort) state_d = ST_IDLE;
        else if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
        else cnt_d = cnt_q + CW'(1);
      end
      ST_FIX:  state_d = abort ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sign_a = src_a[WIDTH-1] & ~is_unsigned;
    sign_b = src_b[WIDTH-1] & ~is_unsigned;
    mag_a  = sign_a ? -src_a : src_a;
    mag_b  = sign_b ? -src_b : src_b;

    fix_hi = core_hi;
    fix_lo = core_lo;
    if (op_div_q == MD_OP_DIV) begin
      if (neg_res_q) fix_lo = -core_lo;
      if (neg_a_q)   fix_hi = -core_hi;
    end else if (neg_res_q) begin
      {fix_hi, fix_lo} = -{core_hi, core_lo};
    end

    // mult: lo=multiplier, opnd=multiplicand; div: lo=dividend, opnd=divisor
    core_ld      = 1'b0;
    core_ld_opnd = 1'b0;
    core_ld_hi   = '0;
    core_ld_lo   = '0;
    core_opnd    = '0;
    if (state_q == ST_PREP) begin
      core_ld      = 1'b1;
      core_ld_opnd = 1'b1;
      core_ld_lo   = (op_div == MD_OP_DIV) ? mag_a : mag_b;
      core_opnd    = (op_div == MD_OP_DIV) ? mag_b : mag_a;
    end else if (state_q == ST_FIX) begin
      core_ld    = 1'b1;
      core_ld_hi = fix_hi;
      core_ld_lo = fix_lo;
    end
    core_en = (state_q == ST_ITER);
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (core_ld),
    .ld_opnd (core_ld_opnd),
    .ld_hi   (core_ld_hi),
    .ld_lo   (core_ld_lo),
    .opnd_i  (core_opnd),
    .en      (core_en),
    .op_div  (op_div_q),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_div_q  <= MD_OP_MULT;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_PREP) begin
        op_div_q  <= op_div;
        neg_res_q <= sign_a ^ sign_b;
        neg_a_q   <= sign_a;
        dz_q      <= (op_div == MD_OP_DIV) && (src_b == '0);
      end
      if (state_q == ST_DONE && !dz_q) begin
        hi_q <= core_hi;
        lo_q <= core_lo;
      end
    end
  end

  assign busy     = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done     = (state_q == ST_DONE);
  assign hilo_w   = (state_q == ST_DONE) && !dz_q;
  assign div_zero = (state_q == ST_DONE) && dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer with hand-computed HI/LO results.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, op_div, abort;
  logic [31:0] src_a, src_b;
  logic        busy, done, hilo_w, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op_div   (op_div),
    .abort    (abort),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hilo_w   (hilo_w),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle (cycle 0) and follows it to the HI/LO update.
  task automatic do_op(input string tag, input logic div, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic exp_dz,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int pulse_at, input logic abort_done);
    int cyc, bc, hw;
    start  = 1'b1;
    op_div = div;
    src_a  = a;
    src_b  = b;
    tick();
    cyc   = 1;
    start = 1'b0;
    bc    = int'(busy);
    hw    = int'(hilo_w);
    while (cyc < 100) begin
      tick();
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == 2) begin
        src_a  = ~a;
        src_b  = b ^ 32'h5A5A_0F0F;
        op_div = ~div;
      end
      if (done) break;
      bc += int'(busy);
      hw += int'(hilo_w);
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " busy@done"}, 64'(busy), 64'(0));
    chk({tag, " hilo_w@done"}, 64'(hilo_w), 64'(!exp_dz));
    chk({tag, " div_zero@done"}, 64'(div_zero), 64'(exp_dz));
    chk({tag, " busy cycles"}, 64'(bc), 64'(exp_lat - 1));
    chk({tag, " early hilo_w"}, 64'(hw), 64'(0));
    abort = abort_done;
    tick();
    abort = 1'b0;
    chk({tag, " hi"}, 64'(hi_out), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo_out), 64'(exp_lo));
    chk({tag, " done after"}, 64'(done), 64'(0));
    chk({tag, " busy after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int ev;
    reset_n = 1'b0;
    start   = 1'b0;
    op_div  = 1'b0;
    abort   = 1'b0;
    src_a   = '0;
    src_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst hilo_w", 64'(hilo_w), 64'(0));
    chk("rst div_zero", 64'(div_zero), 64'(0));
    chk("rst hi", 64'(hi_out), 64'(0));
    chk("rst lo", 64'(lo_out), 64'(0));
    reset_n = 1'b1;
    tick();

    // abort together with start in IDLE drops the request
    start = 1'b1;
    abort = 1'b1;
    src_a = 32'd3;
    src_b = 32'd4;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle abort busy", 64'(busy), 64'(0));
    tick();
    chk("idle abort busy2", 64'(busy), 64'(0));

    do_op("mult 7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 35, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
    do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 35, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    do_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 1'b0,
          32'h0000_0000, 32'h8000_0000, 0, 1'b0);
    do_op("div pos", 1'b1, 32'h1234_5678, 32'h0001_0000, 35, 1'b0,
          32'h0000_5678, 32'h0000_1234, 0, 1'b0);
    do_op("div 5/0", 1'b1, 32'd5, 32'd0, 2, 1'b1,
          32'h0000_5678, 32'h0000_1234, 0, 1'b0);
    do_op("mult min^2", 1'b0, 32'h8000_0000, 32'h8000_0000, 35, 1'b0,
          32'h4000_0000, 32'h0000_0000, 10, 1'b0);

    // abort in cycle 10 of a div
    start  = 1'b1;
    op_div = 1'b1;
    src_a  = 32'd100;
    src_b  = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    chk("abort pre busy", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    ev = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      ev += int'(done) + int'(hilo_w) + int'(busy);
    end
    chk("abort no activity", 64'(ev), 64'(0));
    chk("abort hi kept", 64'(hi_out), 64'(32'h4000_0000));
    chk("abort lo kept", 64'(lo_out), 64'(32'h0000_0000));

    do_op("div 100/7", 1'b1, 32'd100, 32'd7, 35, 1'b0,
          32'd2, 32'd14, 0, 1'b0);
    do_op("div 7/-2 abort@done", 1'b1, 32'd7, 32'hFFFF_FFFE, 35, 1'b0,
          32'd1, 32'hFFFF_FFFD, 0, 1'b1);

    // asynchronous reset in cycle 15 mid-ITER
    start  = 1'b1;
    op_div = 1'b0;
    src_a  = 32'hFFFF_FFFB;
    src_b  = 32'hFFFF_FFFA;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("pre-reset busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'(0));
    chk("async rst done", 64'(done), 64'(0));
    chk("async rst hi", 64'(hi_out), 64'(0));
    chk("async rst lo", 64'(lo_out), 64'(0));
    #2;
    reset_n = 1'b1;
    tick();
    do_op("mult -5x-6", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 35, 1'b0,
          32'd0, 32'd30, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
